sr_ff_bank_ctrl: RTL and testbench

//  Sequences a bank of NFF clocked SR flip-flops on behalf of NREQ requesters.

---
 rtl/sr_ff_bank_ctrl_pkg.sv | 19 +
 rtl/sr_ff_bank_ctrl_rr_arbiter.sv | 34 +++
 rtl/sr_ff_bank_ctrl.sv | 178 +++++++++++++++++
 tb/tb_sr_ff_bank_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/sr_ff_bank_ctrl_pkg.sv
// Shared definitions for the SR flip-flop bank controller: FSM state
// encoding, operation codes and an index-width helper.
package sr_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2
    } state_e;

    localparam logic OP_SET = 1'b1;
    localparam logic OP_CLR = 1'b0;

    // Width needed to encode 0..n-1; never less than 1 bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sr_ff_bank_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter. Searches upward from ptr_i (wrapping)
// and returns the first asserted request as a one-hot grant plus its index.
// The pointer register itself belongs to the instantiating block.
module rr_arbiter
    import sr_ctrl_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = idx_w(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   gnt_o,
    output logic [IDW-1:0] id_o,
    output logic           valid_o
);

    // Priority search starting at ptr_i; the first hit wins.
    always_comb begin : search
        int c;
        gnt_o   = '0;
        id_o    = '0;
        valid_o = 1'b0;
        c       = 0;
        for (int k = 0; k < N; k++) begin
            c = (int'(ptr_i) + k) % N;
            if (!valid_o && req_i[c]) begin
                valid_o  = 1'b1;
                gnt_o[c] = 1'b1;
                id_o     = IDW'(c);
            end
        end
    end

endmodule

// File: rtl/sr_ff_bank_ctrl.sv
// Sequences a bank of clocked SR flip-flops on behalf of several requesters.
// Handshake: a requester holds req[k] high (with stable req_op/req_idx until
// it is granted) until it sees ack[k] for one cycle; err qualifies that ack.
// Requests are granted round-robin; each grant drives a single-cycle S or R
// pulse to one flop and then waits (bounded) for q to reflect the operation.
// S and R are never both high, and at most one flop is driven per cycle.
module sr_ff_bank_ctrl
    import sr_ctrl_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int NFF     = 8,
    parameter int TIMEOUT = 4,
    localparam int IDXW   = idx_w(NFF),
    localparam int IDW    = idx_w(NREQ),
    localparam int CNTW   = idx_w(TIMEOUT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_op,
    input  logic [NREQ*IDXW-1:0] req_idx,
    output logic [NREQ-1:0]      ack,
    output logic                 err,
    output logic                 busy,
    output logic [NFF-1:0]       ff_s,
    output logic [NFF-1:0]       ff_r,
    input  logic [NFF-1:0]       ff_q,
    output state_e               dbg_state,
    output logic [IDW-1:0]       dbg_ptr
);

    state_e              state_q, state_d;
    logic [IDW-1:0]      ptr_q,   ptr_d;
    logic [IDW-1:0]      id_q,    id_d;
    logic                op_q,    op_d;
    logic [IDXW-1:0]     idx_q,   idx_d;
    logic [CNTW-1:0]     cnt_q,   cnt_d;
    logic [NREQ-1:0]     ack_q,   ack_d;
    logic                err_q,   err_d;
    logic                busy_q,  busy_d;
    logic [NFF-1:0]      ff_s_q,  ff_s_d;
    logic [NFF-1:0]      ff_r_q,  ff_r_d;

    logic [NREQ-1:0]     arb_gnt;
    logic [IDW-1:0]      arb_id;
    logic                arb_valid;
    logic [IDXW-1:0]     sel_idx;
    logic                sel_op;
    logic                q_bit;

    rr_arbiter #(
        .N   (NREQ),
        .IDW (IDW)
    ) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .id_o    (arb_id),
        .valid_o (arb_valid)
    );

    // Operands of the requester the arbiter currently favours.
    always_comb begin
        sel_idx = req_idx[arb_id*IDXW +: IDXW];
        sel_op  = req_op[arb_id];
    end

    // q of the latched target flop, observed during CHECK.
    always_comb begin
        q_bit = 1'b0;
        for (int f = 0; f < NFF; f++) begin
            if (int'(idx_q) == f) begin
                q_bit = ff_q[f];
            end
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        op_d    = op_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        err_d   = 1'b0;
        ff_s_d  = '0;
        ff_r_d  = '0;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    id_d  = arb_id;
                    op_d  = sel_op;
                    idx_d = sel_idx;
                    if (int'(sel_idx) >= NFF) begin
                        // Out-of-range target: fail immediately, touch no flop.
                        ack_d[arb_id] = 1'b1;
                        err_d         = 1'b1;
                        ptr_d         = (int'(arb_id) == NREQ - 1) ? '0 : arb_id + 1'b1;
                    end else begin
                        state_d = ST_DRIVE;
                        for (int f = 0; f < NFF; f++) begin
                            if (int'(sel_idx) == f) begin
                                ff_s_d[f] = sel_op;
                                ff_r_d[f] = ~sel_op;
                            end
                        end
                    end
                end
            end
            ST_DRIVE: begin
                // The flop captures the pulse at the end of this cycle.
                state_d = ST_CHECK;
                cnt_d   = '0;
            end
            ST_CHECK: begin
                if (q_bit == op_q) begin
                    ack_d[id_q] = 1'b1;
                    state_d     = ST_IDLE;
                    ptr_d       = (int'(id_q) == NREQ - 1) ? '0 : id_q + 1'b1;
                end else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
                    ack_d[id_q] = 1'b1;
                    err_d       = 1'b1;
                    state_d     = ST_IDLE;
                    ptr_d       = (int'(id_q) == NREQ - 1) ? '0 : id_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, latched transaction and output registers; reset drops any
    // in-flight transaction without acknowledging it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            op_q    <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            ff_s_q  <= '0;
            ff_r_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            ff_s_q  <= ff_s_d;
            ff_r_q  <= ff_r_d;
        end
    end

    assign ack       = ack_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign ff_s      = ff_s_q;
    assign ff_r      = ff_r_q;
    assign dbg_state = state_q;
    assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_sr_ff_bank_ctrl.sv
// Directed bench for sr_ff_bank_ctrl with a behavioural SR flop bank.
// NFF=6 so an index of 7 is representable and out of range.
module tb_sr_ff_bank_ctrl;
    import sr_ctrl_pkg::*;

    localparam int NREQ = 4;
    localparam int NFF  = 6;
    localparam int IDXW = 3;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      req_op;
    logic [NREQ*IDXW-1:0] req_idx;
    logic [NREQ-1:0]      ack;
    logic                 err;
    logic                 busy;
    logic [NFF-1:0]       ff_s;
    logic [NFF-1:0]       ff_r;
    logic [NFF-1:0]       ff_q;
    state_e               dbg_state;
    logic [1:0]           dbg_ptr;

    logic [NFF-1:0]       bank_q = '0;
    logic [NFF-1:0]       stuck  = '0;
    logic [3:0]           exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    sr_ff_bank_ctrl #(.NREQ(NREQ), .NFF(NFF), .TIMEOUT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_op    (req_op),
        .req_idx   (req_idx),
        .ack       (ack),
        .err       (err),
        .busy      (busy),
        .ff_s      (ff_s),
        .ff_r      (ff_r),
        .ff_q      (ff_q),
        .dbg_state (dbg_state),
        .dbg_ptr   (dbg_ptr)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural SR flop bank, optional stuck-at-0 on q
    always @(posedge clk) begin
        for (int f = 0; f < NFF; f++) begin
            if (ff_s[f])      bank_q[f] <= 1'b1;
            else if (ff_r[f]) bank_q[f] <= 1'b0;
        end
    end
    assign ff_q = bank_q & ~stuck;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // invariants sampled every cycle
    always @(negedge clk) begin
        chk("inv_s_and_r", 32'(ff_s & ff_r), 0);
        chk("inv_onehot_drive", 32'($countones(ff_s | ff_r) > 1), 0);
        chk("inv_onehot_ack", 32'($countones(ack) > 1), 0);
        chk("inv_err_wo_ack", 32'(err && (ack == 0)), 0);
    end

    // driver: issue one request at a negedge and follow it to its ack
    task automatic run_txn(input string tag, input int k, input logic op, input logic [2:0] idx,
                           input int exp_cyc, input logic exp_err,
                           input logic [NFF-1:0] exp_s, input logic [NFF-1:0] exp_r);
        bit seen;
        req_op[k]              = op;
        req_idx[k*IDXW +: IDXW] = idx;
        req[k]                 = 1'b1;
        seen = 0;
        for (int c = 1; c <= 12 && !seen; c++) begin
            @(negedge clk);
            chk({tag, "_s"}, 32'(ff_s), (c == 1) ? 32'(exp_s) : 0);
            chk({tag, "_r"}, 32'(ff_r), (c == 1) ? 32'(exp_r) : 0);
            chk({tag, "_busy"}, 32'(busy), 32'(((exp_s | exp_r) != 0) && (c < exp_cyc)));
            if (ack != 0) begin
                seen = 1;
                chk({tag, "_cycle"}, c, exp_cyc);
                chk({tag, "_ack"}, 32'(ack), 32'(4'b0001 << k));
                chk({tag, "_err"}, 32'(err), 32'(exp_err));
                if (!exp_err) chk({tag, "_q"}, 32'(ff_q[idx]), 32'(op));
                req[k] = 1'b0;
            end
        end
        if (!seen) chk({tag, "_noack"}, 0, 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int nack;
        int last;
        rst_n   = 1'b0;
        req     = '0;
        req_op  = '0;
        req_idx = '0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_ack", 32'(ack), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_s", 32'(ff_s), 0);
        chk("rst_r", 32'(ff_r), 0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("rst_ptr", 32'(dbg_ptr), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single set of flag 3 by requester 0
        run_txn("set3", 0, OP_SET, 3'd3, 3, 1'b0, 6'h08, 6'h00);
        chk("set3_ptr", 32'(dbg_ptr), 1);

        // clear flag 5 (already clear) then set it
        run_txn("clr5", 1, OP_CLR, 3'd5, 3, 1'b0, 6'h00, 6'h20);
        run_txn("set5", 2, OP_SET, 3'd5, 3, 1'b0, 6'h20, 6'h00);
        chk("set5_ptr", 32'(dbg_ptr), 3);

        // out-of-range index: immediate error ack, nothing driven
        run_txn("badidx", 3, OP_SET, 3'd7, 1, 1'b1, 6'h00, 6'h00);
        chk("badidx_ptr", 32'(dbg_ptr), 0);

        // stuck flop: q never rises, error after four CHECK cycles
        stuck = 6'b000100;
        run_txn("stuck2", 0, OP_SET, 3'd2, 6, 1'b1, 6'h04, 6'h00);
        stuck = '0;
        chk("stuck2_ptr", 32'(dbg_ptr), 1);

        // reset asserted during DRIVE
        req_op[1]           = OP_SET;
        req_idx[1*IDXW +: IDXW] = 3'd0;
        req[1]              = 1'b1;
        @(negedge clk);
        chk("mid_state", 32'(dbg_state), 32'(ST_DRIVE));
        chk("mid_s", 32'(ff_s), 32'(6'h01));
        rst_n = 1'b0;
        req[1] = 1'b0;
        #1;
        chk("mid_rst_s", 32'(ff_s), 0);
        chk("mid_rst_r", 32'(ff_r), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_ptr", 32'(dbg_ptr), 0);
        repeat (2) begin
            @(negedge clk);
            chk("mid_rst_ack", 32'(ack), 0);
        end
        chk("mid_rst_q0", 32'(ff_q[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // contention: all four held, ptr=0, expect 0,1,2,3,0 three cycles apart
        for (int k = 0; k < NREQ; k++) begin
            req_op[k]              = OP_SET;
            req_idx[k*IDXW +: IDXW] = 3'(k);
        end
        exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req  = 4'b1111;
        nack = 0;
        last = 0;
        for (int c = 1; c <= 40 && nack < 5; c++) begin
            @(negedge clk);
            if (ack != 0) begin
                chk("cont_ack", 32'(ack), 32'(exp_q.pop_front()));
                chk("cont_gap", c - last, 3);
                chk("cont_err", 32'(err), 0);
                last = c;
                nack++;
                if (nack == 5) req = '0;
            end
        end
        chk("cont_count", nack, 5);
        @(negedge clk);
        chk("bank_final", 32'(ff_q), 32'(6'b101111));
        chk("idle_final", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
